// File: rtl/main_func_pkg.sv
// Shared widths, FSM encoding and S1 payload for the dot-product accumulator.
package main_func_pkg;

  // Operand and product widths.
  localparam int unsigned A_W = 7;
  localparam int unsigned B_W = 9;
  localparam int unsigned P_W = 15;

  // Control FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Term registered in stage S1: truncated product plus vector position flags.
  typedef struct packed {
    logic [P_W-1:0] prod;
    logic           first;
    logic           last;
  } term_t;

  // Accumulator width that cannot overflow for a vector of len products.
  function automatic int unsigned acc_width(input int unsigned len);
    return P_W + $clog2(len);
  endfunction

endpackage

// File: rtl/main_func_mul_7ns_9ns_15_1_1.sv
// Combinational unsigned 7x9 multiplier keeping the low 15 product bits.
module main_func_mul_7ns_9ns_15_1_1
  import main_func_pkg::*;
(
  input  logic [A_W-1:0] din0,
  input  logic [B_W-1:0] din1,
  output logic [P_W-1:0] dout
);

  // Operands widened to the product width so the multiply wraps modulo 2^15.
  assign dout = P_W'(din0) * P_W'(din1);

endmodule

// File: rtl/main_func_dot_acc.sv
// Streaming dot-product accumulator: LEN truncated products per result,
// two-stage pipeline (S1 product register, S2 accumulate) with output hold.
module main_func_dot_acc
  import main_func_pkg::*;
#(
  parameter int unsigned LEN       = 16,
  parameter int unsigned ACC_WIDTH = 19
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 clr,
  input  logic [A_W-1:0]       in_a,
  input  logic [B_W-1:0]       in_b,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);

  logic [P_W-1:0]       prod_c;
  logic                 advance_c;
  logic                 accept_c;
  logic                 load_c;
  logic [ACC_WIDTH-1:0] sum_c;

  term_t                s1;
  logic                 s1_vld;
  logic [CNT_W-1:0]     count;
  logic [ACC_WIDTH-1:0] acc;
  logic                 partial;
  state_t               state;

  logic [CNT_W-1:0]     count_n;
  logic                 s1_vld_n;
  logic                 partial_n;
  logic                 busy_n;

  main_func_mul_7ns_9ns_15_1_1 u_mul (
    .din0 (in_a),
    .din1 (in_b),
    .dout (prod_c)
  );

  // Whole pipeline moves only when the output register can take a new result.
  assign advance_c = !out_valid || out_ready;
  assign in_ready  = ap_rst_n && advance_c && !clr;
  assign accept_c  = in_valid && in_ready;
  assign load_c    = advance_c && !clr && s1_vld && s1.last;
  assign sum_c     = (s1.first ? '0 : acc) + ACC_WIDTH'(s1.prod);

  // Next-cycle pipeline occupancy, used by the FSM to pick IDLE or ACCUM.
  always_comb begin
    count_n   = count;
    s1_vld_n  = s1_vld;
    partial_n = partial;
    if (clr) begin
      count_n   = '0;
      s1_vld_n  = 1'b0;
      partial_n = 1'b0;
    end else if (advance_c) begin
      s1_vld_n = accept_c;
      if (accept_c) begin
        count_n = (count == LAST_IDX) ? '0 : count + CNT_W'(1);
      end
      if (s1_vld) begin
        partial_n = !s1.last;
      end
    end
    busy_n = (count_n != '0) || s1_vld_n || partial_n;
  end

  // S1: register the truncated product with its first/last position flags.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1     <= '0;
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= s1_vld_n;
      if (advance_c && !clr) begin
        s1 <= '{prod:  prod_c,
                first: accept_c && (count == '0),
                last:  accept_c && (count == LAST_IDX)};
      end
    end
  end

  // Term counter: position of the next accepted term inside its vector.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      count <= '0;
    end else begin
      count <= count_n;
    end
  end

  // S2: running partial sum; cleared when a vector completes or is flushed.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc     <= '0;
      partial <= 1'b0;
    end else begin
      partial <= partial_n;
      if (clr) begin
        acc <= '0;
      end else if (advance_c && s1_vld) begin
        acc <= s1.last ? '0 : sum_c;
      end
    end
  end

  // Output register: a new result wins over clearing on a handshake.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load_c) begin
      out_data  <= sum_c;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Control FSM tracking idle / accumulating / result-pending phases.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_c) state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (load_c)   state <= ST_HOLD;
          else if (clr) state <= ST_IDLE;
        end
        ST_HOLD: begin
          if (load_c)         state <= ST_HOLD;
          else if (out_ready) state <= busy_n ? ST_ACCUM : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
